// File: rtl/core_pkg.sv
// Shared core types: instruction/PC width, NOP encoding, reset vector
// and the fetch-queue entry bundle passed from fetch to decode.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction queue of fetch_entry_t with synchronous flush.
// Ports: clk, rst, flush, push/push_data, pop, head, count, empty.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Reset and flush both win over any queue traffic.
    assign do_push = push && !rst && !flush;
    assign do_pop  = pop && !empty && !rst && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Extra wrap bit distinguishes full from empty.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch front end: owns the fetch PC, issues 1-cycle imem reads,
// queues returned words and hands them to decode with ValidD/ReadyD.
module fetch_stage
    import core_pkg::*;
#(
    parameter int                  DATA_WIDTH = XLEN,
    parameter int                  DEPTH      = 2,
    parameter logic [XLEN-1:0]     RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                   CLK,
    input  logic                   RST,
    output logic                   ImemEn,
    output logic [DATA_WIDTH-1:0]  ImemAddr,
    input  logic [DATA_WIDTH-1:0]  ImemData,
    input  logic                   Redirect,
    input  logic [DATA_WIDTH-1:0]  RedirectPC,
    output logic [DATA_WIDTH-1:0]  InstrD,
    output logic [DATA_WIDTH-1:0]  PCD,
    output logic [DATA_WIDTH-1:0]  PCPlus4D,
    output logic                   ValidD,
    input  logic                   ReadyD,
    output logic                   MisalignErr
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic                  pop;
    logic                  push;
    logic                  empty;
    logic [AW:0]           count;
    logic [AW+1:0]         credit_use;
    fetch_entry_t          head;
    fetch_entry_t          push_entry;

    assign pop = ValidD && ReadyD;

    // Slots already owed: queued + in flight, minus the one leaving now.
    assign credit_use = {1'b0, count}
                      + {{(AW+1){1'b0}}, inflight}
                      - {{(AW+1){1'b0}}, pop};

    assign ImemEn   = !RST && !Redirect
                   && (credit_use < (AW+2)'(DEPTH));
    assign ImemAddr = fetch_pc;

    // A redirect kills the response arriving this cycle.
    assign push       = inflight && !Redirect;
    assign push_entry = '{pc: inflight_pc, instr: ImemData};

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            MisalignErr <= 1'b0;
        end else begin
            MisalignErr <= Redirect && (RedirectPC[1:0] != 2'b00);
            if (Redirect) begin
                fetch_pc <= {RedirectPC[DATA_WIDTH-1:2], 2'b00};
                inflight <= 1'b0;
            end else begin
                inflight <= ImemEn;
                if (ImemEn) begin
                    fetch_pc    <= fetch_pc + DATA_WIDTH'(4);
                    inflight_pc <= fetch_pc;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .flush     (Redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    assign ValidD   = !empty;
    assign InstrD   = empty ? NOP_INSTR : head.instr;
    assign PCD      = empty ? '0 : head.pc;
    assign PCPlus4D = PCD + DATA_WIDTH'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized + directed bench for fetch_stage against a stream-level
// model: expected PC sequence, fetch address sequence and redirect timing.
module tb_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        CLK;
    logic        RST;
    logic        ImemEn;
    logic [31:0] ImemAddr;
    logic [31:0] ImemData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        ReadyD;
    logic        MisalignErr;

    fetch_stage #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (RPC)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ImemEn      (ImemEn),
        .ImemAddr    (ImemAddr),
        .ImemData    (ImemData),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD),
        .ReadyD      (ReadyD),
        .MisalignErr (MisalignErr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Stream-level reference state.
    logic [31:0] exp_pc;
    logic [31:0] exp_issue;
    logic        exp_mis;
    logic        pend_en;
    logic [31:0] pend_addr;
    logic        hold_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        redir_live;
    int          redir_cyc;
    logic [31:0] redir_tgt;
    logic        in_rst;
    int          out_cnt;
    int          max_out;
    int          cyc;

    logic        obs_en;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_instr;
    logic [31:0] obs_pcd;
    logic [31:0] obs_pc4;
    logic        obs_mis;

    task automatic model_reset();
        exp_pc     = RPC;
        exp_issue  = RPC;
        exp_mis    = 1'b0;
        pend_en    = 1'b0;
        pend_addr  = '0;
        hold_valid = 1'b0;
        redir_live = 1'b0;
        out_cnt    = 0;
    endtask

    task automatic observe();
        logic        xfer;
        logic [31:0] tgt;
        int          age;
        cyc++;
        obs_en    = ImemEn;
        obs_addr  = ImemAddr;
        obs_valid = ValidD;
        obs_instr = InstrD;
        obs_pcd   = PCD;
        obs_pc4   = PCPlus4D;
        obs_mis   = MisalignErr;
        if (RST) begin
            if (in_rst) begin
                check("rst_valid", {31'd0, ValidD}, 32'd0);
                check("rst_instr", InstrD, NOP);
                check("rst_pcd", PCD, 32'd0);
                check("rst_pc4", PCPlus4D, 32'd4);
                check("rst_en", {31'd0, ImemEn}, 32'd0);
                check("rst_mis", {31'd0, MisalignErr}, 32'd0);
            end
            in_rst = 1'b1;
            model_reset();
            return;
        end
        in_rst = 1'b0;

        check("mis", {31'd0, MisalignErr}, {31'd0, exp_mis});
        if (Redirect)
            check("en_redir", {31'd0, ImemEn}, 32'd0);
        if (ImemEn)
            check("imem_addr", ImemAddr, exp_issue);
        if (!ValidD)
            check("empty_nop", InstrD, NOP);
        if (hold_valid) begin
            check("hold_valid", {31'd0, ValidD}, 32'd1);
            check("hold_pcd", PCD, hold_pc);
            check("hold_instr", InstrD, hold_instr);
        end
        if (redir_live) begin
            age = cyc - redir_cyc;
            if (age == 1 || age == 2)
                check("redir_bubble", {31'd0, ValidD}, 32'd0);
            if (age == 3) begin
                check("redir_valid", {31'd0, ValidD}, 32'd1);
                check("redir_pcd", PCD, redir_tgt);
                redir_live = 1'b0;
            end
        end

        xfer = ValidD && ReadyD;
        if (xfer) begin
            check("xfer_pcd", PCD, exp_pc);
            check("xfer_instr", InstrD, mem_of(exp_pc));
            check("xfer_pc4", PCPlus4D, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
        end

        exp_mis    = Redirect && (RedirectPC[1:0] != 2'b00);
        hold_valid = ValidD && !ReadyD && !Redirect;
        hold_pc    = PCD;
        hold_instr = InstrD;
        pend_en    = ImemEn;
        pend_addr  = ImemAddr;
        if (Redirect) begin
            tgt        = {RedirectPC[31:2], 2'b00};
            exp_pc     = tgt;
            exp_issue  = tgt;
            out_cnt    = 0;
            redir_live = 1'b1;
            redir_cyc  = cyc;
            redir_tgt  = tgt;
        end else begin
            if (ImemEn) exp_issue = exp_issue + 32'd4;
            out_cnt = out_cnt + int'(ImemEn) - int'(xfer);
            if (out_cnt > max_out) max_out = out_cnt;
        end
    endtask

    task automatic step(input logic rst, input logic rd,
                        input logic [31:0] rpc, input logic rdy);
        RST        = rst;
        Redirect   = rd;
        RedirectPC = rpc;
        ReadyD     = rdy;
        ImemData   = pend_en ? mem_of(pend_addr) : $urandom;
        @(negedge CLK);
        observe();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, rdy);
    endtask

    logic        wrap_seen;
    logic [31:0] rtgt;

    initial begin
        RST = 1'b1; Redirect = 1'b0; RedirectPC = '0;
        ReadyD = 1'b0; ImemData = '0;
        in_rst = 1'b0; cyc = 0; max_out = 0; redir_cyc = 0;
        redir_tgt = '0; hold_pc = '0; hold_instr = '0;
        model_reset();
        @(posedge CLK); #1;

        // Reset, then free run from RESET_PC.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("first_en", {31'd0, obs_en}, 32'd1);
        check("first_addr", obs_addr, 32'h0);
        check("first_valid", {31'd0, obs_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("second_addr", obs_addr, 32'h4);
        check("second_valid", {31'd0, obs_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("third_addr", obs_addr, 32'h8);
        check("third_valid", {31'd0, obs_valid}, 32'd1);
        check("third_pcd", obs_pcd, 32'h0);
        check("third_pc4", obs_pc4, 32'h4);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            check("steady_valid", {31'd0, obs_valid}, 32'd1);
        end

        // 0x10 is in flight here; redirect to 0x40 kills it.
        step(1'b0, 1'b1, 32'h40, 1'b1);
        check("redir_en_low", {31'd0, obs_en}, 32'd0);
        run(2, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("redir40_pcd", obs_pcd, 32'h40);

        // Backpressure for five cycles.
        run(4, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check("bp_en_low", {31'd0, obs_en}, 32'd0);
        check("bp_valid", {31'd0, obs_valid}, 32'd1);
        check("bp_pcd", obs_pcd, 32'h44);
        run(6, 1'b1);

        // Misaligned redirect.
        step(1'b0, 1'b1, 32'h42, 1'b1);
        check("mis_same", {31'd0, obs_mis}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("mis_pulse", {31'd0, obs_mis}, 32'd1);
        check("mis_addr", obs_addr, 32'h40);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("mis_end", {31'd0, obs_mis}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("mis_pcd", obs_pcd, 32'h40);

        // Reset with a loaded queue and a read outstanding.
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("midrst_valid", {31'd0, obs_valid}, 32'd0);
        check("midrst_instr", obs_instr, NOP);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("postrst_addr", obs_addr, RPC);
        check("postrst_en", {31'd0, obs_en}, 32'd1);
        run(4, 1'b1);

        // Address wrap at the top of memory.
        step(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1);
        wrap_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_valid && obs_pcd == 32'hFFFF_FFFC) begin
                wrap_seen = 1'b1;
                check("wrap_pc4", obs_pc4, 32'h0);
            end
        end
        check("wrap_seen", {31'd0, wrap_seen}, 32'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                step(1'b1, 1'b0, 32'd0, 1'($urandom));
                step(1'b1, 1'b0, 32'd0, 1'($urandom));
            end else if ($urandom_range(0, 99) < 6) begin
                case ($urandom_range(0, 2))
                    0:       rtgt = $urandom;
                    1:       rtgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    default: rtgt = 32'($urandom_range(0, 255));
                endcase
                step(1'b0, 1'b1, rtgt, 1'($urandom));
            end else begin
                step(1'b0, 1'b0, 32'd0, $urandom_range(0, 9) < 7);
            end
        end
        run(6, 1'b1);

        check("credit_bound", {31'd0, max_out <= DEPTH}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
